// File: rtl/trng_word_ctrl.sv
// -----------------------------------------------------------------------------
// trng_word_ctrl
//
// Purpose
//   Sequencer that sits between trng_top and a word consumer. It enables the
//   TRNG, throws away a warm-up run of bits after every enable, packs WORD_W
//   valid bits into a word (first-received bit ends up in the MSB) and offers
//   that word on a valid/ready port. A repetition-count health test watches
//   every accepted raw bit. A run of RC_LIMIT identical bits latches a sticky
//   fault that shuts the TRNG down until the fault is cleared.
//
// Ports
//   i_clk           in   1       system clock, rising edge
//   i_rst           in   1       asynchronous, active-high reset
//   i_run           in   1       level, 1 = keep producing words
//   i_clr_fault     in   1       pulse, leaves FAULT (ignored elsewhere)
//   o_trng_enable   out  1       drives trng_top.enable
//   i_random_bit    in   1       trng_top.random_bit
//   i_random_valid  in   1       trng_top.random_valid, 1-cycle strobe per bit
//   o_word_out      out  WORD_W  assembled word, first-received bit in MSB
//   o_word_valid    out  1       o_word_out is valid
//   i_word_ready    in   1       consumer takes the word on valid && ready
//   o_health_fail   out  1       sticky fault flag
//   o_ctrl_state    out  3       IDLE=0 WARMUP=1 COLLECT=2 HOLD=3 FAULT=4
//
// Parameters
//   WORD_W       output word width, >= 2
//   WARMUP_BITS  valid bits discarded after each enable, >= 1
//   RC_LIMIT     consecutive identical bits that declare a fault, >= 2
// -----------------------------------------------------------------------------
module trng_word_ctrl #(
    parameter int WORD_W      = 32,
    parameter int WARMUP_BITS = 64,
    parameter int RC_LIMIT    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_clr_fault,
    output logic              o_trng_enable,
    input  logic              i_random_bit,
    input  logic              i_random_valid,
    output logic [WORD_W-1:0] o_word_out,
    output logic              o_word_valid,
    input  logic              i_word_ready,
    output logic              o_health_fail,
    output logic [2:0]        o_ctrl_state
);

    // Counter widths are sized so that each counter can hold its terminal
    // value without wrapping.
    localparam int WC_W = $clog2(WARMUP_BITS + 1);
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam int RC_W = $clog2(RC_LIMIT + 1);

    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_BITS - 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [RC_W-1:0] RC_MAX    = RC_W'(RC_LIMIT);
    localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [WC_W-1:0]   r_warm_cnt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [RC_W-1:0]   r_rep_cnt;
    logic              r_last_bit;
    logic [WORD_W-2:0] r_shreg;
    logic [WORD_W-1:0] r_word_out;
    logic              r_word_valid;
    logic              r_trng_enable;
    logic              r_health_fail;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    state_t            w_state_nxt;
    logic              w_active;
    logic              w_accept;
    logic [RC_W-1:0]   w_rep_nxt;
    logic              w_fault;
    logic              w_handshake;
    logic              w_start;
    logic              w_load_word;
    logic              w_shift;
    logic [WORD_W-1:0] w_shreg_full;
    logic              w_enable_nxt;
    logic              w_valid_nxt;
    logic              w_fail_nxt;

    assign w_active    = (r_state == ST_WARMUP) || (r_state == ST_COLLECT) ||
                         (r_state == ST_HOLD);
    assign w_accept    = i_random_valid && w_active;
    assign w_handshake = r_word_valid && i_word_ready;

    // The shift register only keeps WORD_W-1 bits; the bit arriving with the
    // strobe completes the word, so the full word is formed here.
    assign w_shreg_full = {r_shreg, i_random_bit};

    // Repetition count that the current accepted bit would produce. A count
    // of zero marks "no bit seen since the last warm-up entry".
    always_comb begin
        w_rep_nxt = RC_ONE;
        if ((r_rep_cnt != '0) && (i_random_bit == r_last_bit)) begin
            if (r_rep_cnt == RC_MAX) begin
                w_rep_nxt = RC_MAX;
            end else begin
                w_rep_nxt = r_rep_cnt + RC_ONE;
            end
        end
    end

    assign w_fault = w_accept && (w_rep_nxt == RC_MAX);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Fault detection beats run=0, which beats word
    // completion and the handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt = ST_WARMUP;
                end
            end
            ST_WARMUP, ST_COLLECT, ST_HOLD: begin
                if (w_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (!i_run) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    case (r_state)
                        ST_WARMUP: begin
                            if (w_accept && (r_warm_cnt == WARM_LAST)) begin
                                w_state_nxt = ST_COLLECT;
                            end
                        end
                        ST_COLLECT: begin
                            if (w_accept && (r_bit_cnt == BIT_LAST)) begin
                                w_state_nxt = ST_HOLD;
                            end
                        end
                        default: begin
                            if (w_handshake) begin
                                w_state_nxt = ST_COLLECT;
                            end
                        end
                    endcase
                end
            end
            ST_FAULT: begin
                if (i_clr_fault) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath control decode. Registered outputs are decoded from
    // the next state so that they line up with o_ctrl_state after each edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_enable_nxt = (w_state_nxt == ST_WARMUP) || (w_state_nxt == ST_COLLECT) ||
                       (w_state_nxt == ST_HOLD);
        w_valid_nxt  = (w_state_nxt == ST_HOLD);
        w_fail_nxt   = (w_state_nxt == ST_FAULT);
        w_start      = (r_state == ST_IDLE) && (w_state_nxt == ST_WARMUP);
        w_load_word  = (r_state == ST_COLLECT) && (w_state_nxt == ST_HOLD);
        // The bit that trips the health test never enters the word.
        w_shift      = (r_state == ST_COLLECT) && w_accept && !w_fault;
    end

    // -------------------------------------------------------------------------
    // Counters, health test and word assembly
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_warm_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_rep_cnt     <= '0;
            r_last_bit    <= 1'b0;
            r_shreg       <= '0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_trng_enable <= 1'b0;
            r_health_fail <= 1'b0;
        end else begin
            r_word_valid  <= w_valid_nxt;
            r_trng_enable <= w_enable_nxt;
            r_health_fail <= w_fail_nxt;

            // Warm-up count only lives inside WARMUP; it restarts on entry.
            if (w_start || (w_state_nxt != ST_WARMUP)) begin
                r_warm_cnt <= '0;
            end else if ((r_state == ST_WARMUP) && w_accept) begin
                r_warm_cnt <= r_warm_cnt + WC_W'(1);
            end

            // Bit count restarts whenever COLLECT is (re)entered, so bits
            // strobed during HOLD or the handshake cycle never count.
            if ((r_state != ST_COLLECT) || (w_state_nxt != ST_COLLECT)) begin
                r_bit_cnt <= '0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end

            // The repetition count spans WARMUP/COLLECT/HOLD and is only
            // restarted by a fresh enable.
            if (w_start) begin
                r_rep_cnt  <= '0;
                r_last_bit <= 1'b0;
            end else if (w_accept) begin
                r_rep_cnt  <= w_rep_nxt;
                r_last_bit <= i_random_bit;
            end

            if (w_shift) begin
                r_shreg <= w_shreg_full[WORD_W-2:0];
            end

            if (w_load_word) begin
                r_word_out <= w_shreg_full;
            end
        end
    end

    assign o_ctrl_state  = r_state;
    assign o_trng_enable = r_trng_enable;
    assign o_word_out    = r_word_out;
    assign o_word_valid  = r_word_valid;
    assign o_health_fail = r_health_fail;

endmodule
